stereo_moving_avg: RTL and testbench

//  Parametrised multi-channel moving-average (boxcar FIR) noise filter for the audio path.

---
 rtl/audio_filt_pkg.sv | 27 ++
 rtl/avg_window_ch.sv | 73 +++++++
 rtl/stereo_moving_avg.sv | 124 ++++++++++++
 tb/tb_stereo_moving_avg.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/audio_filt_pkg.sv
// Shared constants and helpers for the audio moving-average filter.
//   DEFAULT_W / DEFAULT_N / DEFAULT_CH : default sample width, log2 window depth, channel count
//   SEXT_MAX                           : widest value the sign-extension helper handles
//   sext(x, from_width)                : sign-extends the low from_width bits of x to SEXT_MAX bits
package audio_filt_pkg;

  localparam int DEFAULT_W  = 24;
  localparam int DEFAULT_N  = 3;
  localparam int DEFAULT_CH = 2;
  localparam int SEXT_MAX   = 64;

  // Callers cast the result down to the width they need.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] x,
                                               input int from_width);
    logic [SEXT_MAX-1:0] r;
    r = x;
    for (int i = 0; i < SEXT_MAX; i++) begin
      if (i >= from_width) begin
        r[i] = x[from_width-1];
      end else begin
        r[i] = x[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/avg_window_ch.sv
// One channel of the boxcar filter: 2^N-deep sample history plus a
// full-precision running sum.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : synchronous flush of the running sum
//   i_we         : a sample is accepted this cycle
//   i_full       : window already holds 2^N samples, so the oldest one leaves
//   i_wr_ptr     : history slot holding the oldest sample / receiving the new one
//   i_x          : incoming sample (two's complement)
//   o_result     : window average for the sum that includes i_x (combinational)
module avg_window_ch
  import audio_filt_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_we,
  input  logic         i_full,
  input  logic [N-1:0] i_wr_ptr,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_result
);

  localparam int DEPTH = 1 << N;
  localparam int SW    = W + N;

  logic [W-1:0]  r_buf [DEPTH];
  logic [SW-1:0] r_sum;
  logic [SW-1:0] w_x_ext;
  logic [SW-1:0] w_old_ext;
  logic [SW-1:0] w_sum_nxt;

  // Next running sum; the oldest sample only leaves once the window is full,
  // so stale history after reset/clear is never subtracted.
  always_comb begin
    w_x_ext = SW'(sext({{(SEXT_MAX-W){1'b0}}, i_x}, W));
    if (i_full) begin
      w_old_ext = SW'(sext({{(SEXT_MAX-W){1'b0}}, r_buf[i_wr_ptr]}, W));
    end else begin
      w_old_ext = {SW{1'b0}};
    end
    w_sum_nxt = r_sum + w_x_ext - w_old_ext;
    // Bits [W+N-1:N] are exactly sum >>> N; the range always fits in W bits.
    o_result  = W'(w_sum_nxt >> N);
  end

  // Running-sum register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= {SW{1'b0}};
    end else if (i_clr) begin
      r_sum <= {SW{1'b0}};
    end else if (i_we) begin
      r_sum <= w_sum_nxt;
    end else begin
      r_sum <= r_sum;
    end
  end

  // Sample history; the slot is read above before being overwritten here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= {W{1'b0}};
      end
    end else if (i_we) begin
      r_buf[i_wr_ptr] <= i_x;
    end
  end

endmodule

// File: rtl/stereo_moving_avg.sv
// Multi-channel moving-average (boxcar) noise filter with valid/ready
// handshake, bypass and synchronous clear.
//   CLOCK_50  : clock (posedge)          reset     : synchronous, active-high
//   clear     : flush window state       bypass    : pass raw samples through
//   in_valid / in_ready / in_data        : input frame handshake, channel c at [c*W +: W]
//   out_valid / out_ready / out_data     : registered result frame handshake
//   fill_done : 2^N frames accepted since the last reset/clear
module stereo_moving_avg
  import audio_filt_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int N  = DEFAULT_N,
  parameter int CH = DEFAULT_CH
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          clear,
  input  logic          bypass,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CH*W-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CH*W-1:0] out_data,
  output logic          fill_done
);

  localparam logic [N:0] C_FULL = {1'b1, {N{1'b0}}};

  logic [N-1:0]    r_wr_ptr;
  logic [N:0]      r_count;
  logic            r_out_valid;
  logic [CH*W-1:0] r_out_data;
  logic            r_fill_done;

  logic            w_in_ready;
  logic            w_acc;
  logic            w_full;
  logic [N-1:0]    w_wr_ptr_nxt;
  logic [N:0]      w_count_nxt;
  logic [CH*W-1:0] w_result;
  logic [CH*W-1:0] w_frame_nxt;

  // Handshake, fill tracking and output frame selection.
  always_comb begin
    w_in_ready   = ~clear & (~r_out_valid | out_ready);
    w_acc        = in_valid & w_in_ready;
    w_full       = (r_count == C_FULL);
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (clear) begin
      w_wr_ptr_nxt = {N{1'b0}};
      w_count_nxt  = {(N+1){1'b0}};
    end else if (w_acc) begin
      w_wr_ptr_nxt = r_wr_ptr + N'(1);
      if (w_full) begin
        w_count_nxt = r_count;
      end else begin
        w_count_nxt = r_count + (N+1)'(1);
      end
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_count_nxt  = r_count;
    end
    if (bypass) begin
      w_frame_nxt = in_data;
    end else begin
      w_frame_nxt = w_result;
    end
  end

  genvar c;
  generate
    for (c = 0; c < CH; c++) begin : g_ch
      avg_window_ch #(.W(W), .N(N)) u_ch (
        .i_clk    (CLOCK_50),
        .i_rst    (reset),
        .i_clr    (clear),
        .i_we     (w_acc),
        .i_full   (w_full),
        .i_wr_ptr (r_wr_ptr),
        .i_x      (in_data[c*W +: W]),
        .o_result (w_result[c*W +: W])
      );
    end
  endgenerate

  // Window pointer, fill count and fill flag; fill_done tracks the count
  // after this cycle's accept so it rises together with the 2^N-th result.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr_ptr    <= {N{1'b0}};
      r_count     <= {(N+1){1'b0}};
      r_fill_done <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_count     <= w_count_nxt;
      r_fill_done <= (w_count_nxt == C_FULL);
    end
  end

  // Output register; clear leaves a pending frame untouched.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {(CH*W){1'b0}};
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_frame_nxt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign fill_done = r_fill_done;

endmodule

// File: tb/tb_stereo_moving_avg.sv
module tb_stereo_moving_avg;

  logic        clk = 1'b0;
  logic        reset, clear, bypass, in_valid, out_ready;
  logic        in_ready, out_valid, fill_done;
  logic [47:0] in_data, out_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stereo_moving_avg #(.W(24), .N(3), .CH(2)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .clear     (clear),
    .bypass    (bypass),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill_done (fill_done)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
  endtask

  initial begin
    logic [23:0] el, er;
    longint      s;
    int          ke;

    reset = 1'b1; clear = 1'b0; bypass = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_data = 48'd0;
    step(); step();
    reset = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk ("rst_out_data", out_data, 48'd0);
    chk1("rst_fill_done", fill_done, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);

    // 1: constant 0x000800 ramps 0x100 per frame up to 0x800
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1; in_data = {24'h000800, 24'h000800};
      step();
      ke = (k > 8) ? 8 : k;
      el = 24'(ke * 256);
      chk1("t1_valid", out_valid, 1'b1);
      chk ("t1_data", out_data, {el, el});
      chk1("t1_fill", fill_done, (k >= 8) ? 1'b1 : 1'b0);
    end
    in_valid = 1'b0;
    step();
    chk1("t1_drain", out_valid, 1'b0);

    // 2: L = -8, R = +8
    do_clear();
    chk1("t2_fill_clr", fill_done, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1; in_data = {24'h000008, 24'hFFFFF8};
      step();
      ke = (k > 8) ? 8 : k;
      el = 24'(-ke);
      er = 24'(ke);
      chk("t2_data", out_data, {er, el});
    end

    // 3: full-scale extremes, no wrap
    do_clear();
    for (int k = 1; k <= 12; k++) begin
      in_valid = 1'b1; in_data = {24'h800000, 24'h7FFFFF};
      step();
      ke = (k > 8) ? 8 : k;
      s  = (longint'(ke) * 64'sd8388607) >>> 3;
      el = 24'(s);
      s  = -(longint'(ke) <<< 20);
      er = 24'(s);
      chk("t3_data", out_data, {er, el});
    end
    chk("t3_final", out_data, {24'h800000, 24'h7FFFFF});

    // 4: ramp x_k = 16k against a sliding-sum model
    do_clear();
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b1; in_data = {24'(16 * k), 24'(16 * k)};
      step();
      s = 0;
      for (int j = k - 7; j <= k; j++) begin
        if (j >= 1) s += 16 * j;
      end
      el = 24'(s >>> 3);
      chk("t4_ramp", out_data, {el, el});
    end
    in_valid = 1'b0;
    step();

    // 5: backpressure holds data and blocks input
    do_clear();
    out_ready = 1'b0; in_valid = 1'b1; in_data = {24'h000800, 24'h000800};
    #1;
    chk1("t5_ready_pre", in_ready, 1'b1);
    step();
    chk1("t5_ready_blk", in_ready, 1'b0);
    chk ("t5_first", out_data, {24'h000100, 24'h000100});
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("t5_hold_valid", out_valid, 1'b1);
      chk ("t5_hold_data", out_data, {24'h000100, 24'h000100});
      chk1("t5_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk1("t5_ready_rel", in_ready, 1'b1);
    step();
    chk ("t5_second", out_data, {24'h000200, 24'h000200});
    in_valid = 1'b0;
    step();
    chk1("t5_done", out_valid, 1'b0);

    // 6: clear with a pending frame, bypass, reset mid-stream
    do_clear();
    for (int k = 1; k <= 12; k++) begin
      in_valid = 1'b1; in_data = {24'h000800, 24'h000800};
      step();
    end
    chk1("t6_fill_set", fill_done, 1'b1);
    in_valid = 1'b1; out_ready = 1'b0; clear = 1'b1;
    #1;
    chk1("t6_clr_ready", in_ready, 1'b0);
    step();
    chk1("t6_clr_fill", fill_done, 1'b0);
    chk1("t6_pend_valid", out_valid, 1'b1);
    chk ("t6_pend_data", out_data, {24'h000800, 24'h000800});
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk1("t6_pend_xfer", out_valid, 1'b0);
    in_valid = 1'b1; in_data = {24'h000800, 24'h000800};
    step();
    chk ("t6_after_clr", out_data, {24'h000100, 24'h000100});
    bypass = 1'b1; in_data = {24'h123456, 24'h123456};
    step();
    chk ("t6_bypass", out_data, {24'h123456, 24'h123456});
    bypass = 1'b0; in_data = {24'h000800, 24'h000800};
    step();
    // window now holds 0x800, 0x123456, 0x800 -> 0x124456 >>> 3
    chk ("t6_unbypass", out_data, {24'h02488A, 24'h02488A});
    reset = 1'b1;
    step();
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk ("t6_rst_data", out_data, 48'd0);
    chk1("t6_rst_fill", fill_done, 1'b0);
    reset = 1'b0;
    step();
    chk ("t6_post_rst", out_data, {24'h000100, 24'h000100});
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
